// File: rtl/proc_sequencer_if.sv
// Host/proc-side bundle for proc_sequencer: instruction push port, proc issue bus and status.
// master = host/bench side, slave = sequencer side.
interface proc_sequencer_if #(
  parameter int ADDRW = 2,
  parameter int CNTW  = 8
) ();
  logic              InValid;
  logic              InReady;
  logic [5:0]        InFunc;
  logic [7:0]        InData;
  logic              w;
  logic [1:0]        F;
  logic [1:0]        Rx;
  logic [1:0]        Ry;
  logic [7:0]        Data;
  logic              ProcDone;
  logic              Busy;
  logic [ADDRW:0]    Level;
  logic [CNTW-1:0]   IssueCount;
  logic              Error;

  modport master (
    output InValid, InFunc, InData, ProcDone,
    input  InReady, w, F, Rx, Ry, Data, Busy, Level, IssueCount, Error
  );

  modport slave (
    input  InValid, InFunc, InData, ProcDone,
    output InReady, w, F, Rx, Ry, Data, Busy, Level, IssueCount, Error
  );
endinterface

// File: rtl/proc_sequencer.sv
// Instruction FIFO and one-at-a-time issue controller for the 4-register bus processor.
// Optional watchdog on the WAIT state: define PROC_SEQ_WATCHDOG_EN.
module proc_sequencer #(
  parameter int ADDRW = 2,
  parameter int CNTW  = 8,
  parameter int TMO   = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  proc_sequencer_if.slave   bus
);
  localparam int DEPTH = 1 << ADDRW;
  localparam logic [ADDRW:0] DEPTH_L = (ADDRW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_reg, state_next;
  logic [13:0]       mem [DEPTH];
  logic [ADDRW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [ADDRW:0]    level_reg;
  logic [1:0]        f_reg, rx_reg, ry_reg;
  logic [7:0]        data_reg;
  logic              w_reg;
  logic [CNTW-1:0]   count_reg;
  logic              full, not_empty, push, pop, done_ok, timeout;

  // Readiness comes from the registered level only, so a pop in the same cycle never frees a slot early.
  assign full      = (level_reg == DEPTH_L);
  assign not_empty = (level_reg != '0);
  assign push      = bus.InValid & ~full;

`ifdef PROC_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(TMO + 1);
  logic [WDW-1:0] wd_reg;
  logic           error_reg;

  assign timeout = (state_reg == WAIT) && !bus.ProcDone && (wd_reg == WDW'(TMO - 1));

  // Counter sits at zero outside WAIT, so it is clear on every entry into WAIT.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wd_reg    <= '0;
      error_reg <= 1'b0;
    end else begin
      if (state_reg != WAIT)
        wd_reg <= '0;
      else if (!timeout)
        wd_reg <= wd_reg + WDW'(1);
      if (timeout)
        error_reg <= 1'b1;
    end
  end

  assign bus.Error = error_reg;
`else
  assign timeout   = 1'b0;
  // TMO only matters with the watchdog built in; a negative limit is meaningless.
  assign bus.Error = (TMO < 0);
`endif

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    done_ok    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (not_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (bus.ProcDone) begin
          done_ok = 1'b1;
          if (not_empty) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Queue storage has no reset so it maps onto RAM; validity is tracked by the pointers.
  always_ff @(posedge Clock) begin
    if (push)
      mem[wr_ptr_reg] <= {bus.InFunc, bus.InData};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      f_reg      <= '0;
      rx_reg     <= '0;
      ry_reg     <= '0;
      data_reg   <= '0;
      w_reg      <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      w_reg     <= pop;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + ADDRW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ADDRW'(1);
        {f_reg, rx_reg, ry_reg, data_reg} <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (ADDRW+1)'(1);
        2'b01:   level_reg <= level_reg - (ADDRW+1)'(1);
        default: level_reg <= level_reg;
      endcase
      if (done_ok)
        count_reg <= count_reg + CNTW'(1);
    end
  end

  assign bus.InReady    = ~full;
  assign bus.w          = w_reg;
  assign bus.F          = f_reg;
  assign bus.Rx         = rx_reg;
  assign bus.Ry         = ry_reg;
  assign bus.Data       = data_reg;
  assign bus.Busy       = (state_reg != IDLE);
  assign bus.Level      = level_reg;
  assign bus.IssueCount = count_reg;
endmodule
